// File: rtl/instruction_fetch.sv
// instruction_fetch: small instruction memory with a two-entry prefetch FIFO,
// a registered read port, a branch/jump redirect and a valid/ready
// instruction output.
// Optional feature macro: IFETCH_BOUNDS_CHECK_EN. When it is defined, an
// out-of-range fetch raises a sticky fault and out-of-range loads are dropped.
// Otherwise the word index wraps modulo DEPTH.
module instruction_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  fault
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int FULL_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FAULT
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // The read in flight. Its data and address become valid one edge after the issue.
    logic                  rd_pending;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] rd_pc;

    // Two-entry output FIFO.
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [ADDR_WIDTH-1:0] fifo_pc [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic [ADDR_WIDTH-1:0] issue_pc;
    logic [FULL_W-1:0]     issue_full_idx;
    logic [FULL_W-1:0]     load_full_idx;
    logic [IDX_W-1:0]      issue_idx;
    logic [IDX_W-1:0]      load_idx;
    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;
    logic                  want_issue;
    logic                  issue;
    logic                  fault_hit;
    logic                  load_ok;
    logic                  unused_bits;

    // Issue decision: the read that starts this cycle and the address it uses.
    // A redirect bypasses its target straight into the issue, so the first
    // redirected word arrives two cycles later. A same-cycle pop frees one slot.
    always_comb begin
        redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        issue_pc         = redirect_valid ? redirect_aligned : pc;
        issue_full_idx   = issue_pc[ADDR_WIDTH-1:2];
        load_full_idx    = load_addr[ADDR_WIDTH-1:2];
        issue_idx        = issue_full_idx[IDX_W-1:0];
        load_idx         = load_full_idx[IDX_W-1:0];
        pop              = (count != 2'd0) && instr_ready && !redirect_valid;
        push             = rd_pending && !redirect_valid;
        occupancy        = {1'b0, count} + {2'b00, rd_pending} - {2'b00, pop};
        want_issue       = enable && (state != FAULT) &&
                           (redirect_valid || (occupancy < 3'd2));
`ifdef IFETCH_BOUNDS_CHECK_EN
        issue            = want_issue && (issue_full_idx < FULL_W'(DEPTH));
        fault_hit        = want_issue && (issue_full_idx >= FULL_W'(DEPTH));
        load_ok          = load_full_idx < FULL_W'(DEPTH);
`else
        issue            = want_issue;
        fault_hit        = 1'b0;
        load_ok          = 1'b1;
`endif
    end

    // Next-state logic. An out-of-range issue attempt locks the block in FAULT until reset.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fault_hit) begin
                    state_next = FAULT;
                end else if (enable) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (fault_hit) begin
                    state_next = FAULT;
                end else if (!enable) begin
                    state_next = IDLE;
                end
            end
            FAULT: state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Program memory with a registered read port. Reset does not touch it.
    // A load and a read of the same word in one cycle return the old word.
    always_ff @(posedge clk) begin
        if (load_en && load_ok) begin
            mem[load_idx] <= load_data;
        end
        if (issue) begin
            rd_data <= mem[issue_idx];
            rd_pc   <= issue_pc;
        end
    end

    // PC and in-flight tracking. A redirect replaces any older read with the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (issue) begin
                pc <= issue_pc + ADDR_WIDTH'(4);
            end else if (redirect_valid) begin
                pc <= redirect_aligned;
            end
        end
    end

    // Output FIFO. A redirect flushes it and drops the read that would have landed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_pc[0]   <= '0;
            fifo_pc[1]   <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_pc[wr_ptr]   <= rd_pc;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign instr_valid = (count != 2'd0);
    assign instr_data  = instr_valid ? fifo_data[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : '0;

`ifdef IFETCH_BOUNDS_CHECK_EN
    assign fault = (state == FAULT);
`else
    assign fault = 1'b0;
`endif

    // The block ignores the byte-offset bits and, when wrapping, the upper index bits.
    assign unused_bits = ^{load_addr[1:0], redirect_pc[1:0], issue_full_idx, load_full_idx};

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with default parameters.
// It reads IFETCH_BOUNDS_CHECK_EN to choose the expected behaviour at the end of memory.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] words [16];

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fault          (fault)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        vectors++;
        if (instr_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 00000000", instr_data); end
        vectors++;
        if (instr_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc: got %h expected 00000000", instr_pc); end
        vectors++;
        if (fault !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load();
        for (int i = 0; i < 16; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i * 4 + (i % 4));
            load_data = words[i];
            step();
        end
        load_en = 1'b0;
    endtask

    task automatic test_stream();
        enable      = 1'b1;
        instr_ready = 1'b1;
        step();
        vectors++;
        if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_early_valid: got %b expected 0", instr_valid); end
        step();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4) || instr_data !== words[i]) begin
                miscompares++;
                $display("[TB] FAIL stream[%0d]: got v=%b pc=%h data=%h expected v=1 pc=%h data=%h",
                         i, instr_valid, instr_pc, instr_data, 32'(i * 4), words[i]);
            end
            step();
        end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr_data !== words[4]) begin
                miscompares++;
                $display("[TB] FAIL stall[%0d]: got v=%b pc=%h data=%h expected v=1 pc=00000010 data=%h",
                         k, instr_valid, instr_pc, instr_data, words[4]);
            end
            step();
        end
        instr_ready = 1'b1;
        for (int i = 4; i < 8; i++) begin
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4) || instr_data !== words[i]) begin
                miscompares++;
                $display("[TB] FAIL stall_resume[%0d]: got v=%b pc=%h data=%h expected v=1 pc=%h data=%h",
                         i, instr_valid, instr_pc, instr_data, 32'(i * 4), words[i]);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000000B;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL redirect_flush: got v=%b expected 0", instr_valid); end
        step();
        for (int i = 2; i < 5; i++) begin
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4) || instr_data !== words[i]) begin
                miscompares++;
                $display("[TB] FAIL redirect_word[%0d]: got v=%b pc=%h data=%h expected v=1 pc=%h data=%h",
                         i, instr_valid, instr_pc, instr_data, 32'(i * 4), words[i]);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000038;
        step();
        redirect_valid = 1'b0;
        step();
        for (int i = 14; i < 16; i++) begin
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4) || instr_data !== words[i]) begin
                miscompares++;
                $display("[TB] FAIL wrap_tail[%0d]: got v=%b pc=%h data=%h expected v=1 pc=%h data=%h",
                         i, instr_valid, instr_pc, instr_data, 32'(i * 4), words[i]);
            end
            step();
        end
`ifdef IFETCH_BOUNDS_CHECK_EN
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (instr_valid !== 1'b0 || fault !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL bounds_fault[%0d]: got v=%b fault=%b expected v=0 fault=1", k, instr_valid, fault);
            end
            step();
        end
`else
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(64 + k * 4) || instr_data !== words[k] || fault !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL wrap_word[%0d]: got v=%b pc=%h data=%h fault=%b expected v=1 pc=%h data=%h fault=0",
                         k, instr_valid, instr_pc, instr_data, fault, 32'(64 + k * 4), words[k]);
            end
            step();
        end
`endif
    endtask

    task automatic test_async_reset();
        instr_ready = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0 || fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got v=%b pc=%h data=%h fault=%b expected all zero",
                     instr_valid, instr_pc, instr_data, fault);
        end
        step();
        rst_n       = 1'b1;
        enable      = 1'b1;
        instr_ready = 1'b1;
        step();
        vectors++;
        if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_early: got v=%b expected 0", instr_valid); end
        step();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4) || instr_data !== words[i]) begin
                miscompares++;
                $display("[TB] FAIL post_reset[%0d]: got v=%b pc=%h data=%h expected v=1 pc=%h data=%h",
                         i, instr_valid, instr_pc, instr_data, 32'(i * 4), words[i]);
            end
            step();
        end
    endtask

    task automatic test_reload();
        enable = 1'b0;
        repeat (4) step();
        vectors++;
        if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL drain: got v=%b expected 0", instr_valid); end
        load_en   = 1'b1;
        load_addr = 32'h00000004;
        load_data = 32'hDEADBEEF;
        step();
        load_en        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000004;
        enable         = 1'b1;
        step();
        redirect_valid = 1'b0;
        vectors++;
        if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reload_early: got v=%b expected 0", instr_valid); end
        step();
        vectors++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL reload_word: got v=%b pc=%h data=%h expected v=1 pc=00000004 data=deadbeef",
                     instr_valid, instr_pc, instr_data);
        end
    endtask

    // Run the directed scenarios in order
    initial begin
        words[0] = 32'h00430820;
        words[1] = 32'h00C52020;
        words[2] = 32'h01093820;
        words[3] = 32'h016C5020;
        for (int i = 4; i < 16; i++) begin
            words[i] = 32'hA5000000 + 32'(i * 32'h00010101);
        end
        enable         = 1'b0;
        load_en        = 1'b0;
        load_addr      = '0;
        load_data      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;

        test_reset();
        test_load();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_reload();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
